// File: rtl/arbiter_8_way_16.sv
// Round-robin arbiter steering eight 16-bit requesters onto one registered output word.
// Define ARB_LOCK_EN to add a lock input that suppresses the HOLD_MAX forced rotation.
module arbiter_8_way_16 #(
    parameter int HOLD_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   req,
    input  logic [127:0] in,
`ifdef ARB_LOCK_EN
    input  logic         lock,
`endif
    output logic [7:0]   gnt,
    output logic [2:0]   sel,
    output logic [15:0]  out,
    output logic         out_valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD = 4'(HOLD_MAX);

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] pick;
    logic [3:0] beats;
    logic [4:0] beats_next;
    logic       rotate;

    // Scan from the highest offset down so the lowest offset past ptr wins.
    always_comb begin
        pick = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr + 3'(i)]) pick = ptr + 3'(i);
        end
    end

    assign beats_next = {1'b0, beats} + 5'd1;

`ifdef ARB_LOCK_EN
    assign rotate = !lock && (beats_next >= {1'b0, HOLD});
`else
    assign rotate = (beats_next == {1'b0, HOLD});
`endif

    // NOTE: every state register uses <= so all updates land together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            sel       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            beats     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (|req) begin
                        gnt   <= 8'd1 << pick;
                        sel   <= pick;
                        beats <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (req[sel]) begin
                        out       <= in[{sel, 4'b0000} +: 16];
                        out_valid <= 1'b1;
                        beats     <= (beats_next > {1'b0, HOLD}) ? HOLD : beats_next[3:0];
                        if (rotate) begin
                            gnt   <= '0;
                            ptr   <= sel + 3'd1;
                            state <= IDLE;
                        end
                    end else begin
                        gnt       <= '0;
                        out_valid <= 1'b0;
                        ptr       <= sel + 3'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_8_way_16.sv
// Randomized bench for arbiter_8_way_16 against a behavioural round-robin model.
// Compile with +define+ARB_LOCK_EN to also exercise the lock feature.
module tb_arbiter_8_way_16;

    localparam int HOLD = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   req;
    logic [127:0] in;
    logic         lock;
    logic [7:0]   gnt;
    logic [2:0]   sel;
    logic [15:0]  out;
    logic         out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: owner is the granted source index, or -1 while idle.
    int          m_owner;
    int          m_ptr;
    int          m_beats;
    int          m_sel;
    logic [15:0] m_out;
    logic        m_valid;

    arbiter_8_way_16 #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in        (in),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_sel   = 0;
        m_out   = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        if (m_owner < 0) begin
            m_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (m_owner < 0 && req[(m_ptr + i) % 8]) begin
                    m_owner = (m_ptr + i) % 8;
                    m_sel   = m_owner;
                    m_beats = 0;
                end
            end
        end else if (req[m_owner]) begin
            m_out   = in[16*m_owner +: 16];
            m_valid = 1'b1;
            m_beats = m_beats + 1;
            if (m_beats >= HOLD && !lock) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end
            if (m_beats > HOLD) m_beats = HOLD;
        end else begin
            m_valid = 1'b0;
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end
    endtask

    function automatic logic [27:0] expected();
        logic [7:0] g;
        g = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
        return {g, 3'(m_sel), m_out, m_valid};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        lock  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic int idx_of(logic [7:0] g);
        for (int i = 0; i < 8; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        in    = '0;
        lock  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({gnt, sel, out, out_valid} !== 28'h0)
            $display("FAIL reset_state: dut=%h want=%h", {gnt, sel, out, out_valid}, 28'h0);
        else n_pass++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        in        = '0;
        in[47:32] = 16'hBEEF;
        req       = 8'h04;
        for (int c = 1; c <= 6; c++) begin
            cycle();
            n_checks++;
            if ({gnt, sel, out, out_valid} !== expected())
                $display("FAIL single cyc%0d: dut=%h model=%h", c, {gnt, sel, out, out_valid}, expected());
            else n_pass++;
            if (c == 5) begin
                n_checks++;
                if (gnt !== 8'h00 || out !== 16'hBEEF || out_valid !== 1'b1)
                    $display("FAIL single_rotate: gnt=%h out=%h v=%b want 00 BEEF 1", gnt, out, out_valid);
                else n_pass++;
            end
        end
        n_checks++;
        if (gnt !== 8'h04) $display("FAIL single_regrant: gnt=%h want 04", gnt);
        else n_pass++;
        // Asynchronous reset while granted must clear outputs without waiting for an edge.
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({gnt, sel, out, out_valid} !== 28'h0)
            $display("FAIL reset_mid_grant: dut=%h want=%h", {gnt, sel, out, out_valid}, 28'h0);
        else n_pass++;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = 8'h24;
        cycle();
        n_checks++;
        if (gnt !== 8'h04 || {gnt, sel, out, out_valid} !== expected())
            $display("FAIL reset_first_grant: dut=%h model=%h", {gnt, sel, out, out_valid}, expected());
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int         order[$];
        logic [7:0] prev;
        apply_reset();
        req  = 8'hFF;
        prev = 8'h00;
        for (int c = 0; c < 46; c++) begin
            in = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            n_checks++;
            if ({gnt, sel, out, out_valid} !== expected())
                $display("FAIL rr cyc%0d: dut=%h model=%h", c, {gnt, sel, out, out_valid}, expected());
            else n_pass++;
            if (gnt !== 8'h00 && prev === 8'h00) order.push_back(idx_of(gnt));
            prev = gnt;
        end
        n_checks++;
        if (order.size() < 9) $display("FAIL rr_count: grants=%0d want>=9", order.size());
        else n_pass++;
        for (int i = 0; i < 9 && i < order.size(); i++) begin
            n_checks++;
            if (order[i] != i % 8) $display("FAIL rr_order[%0d]: got=%0d want=%0d", i, order[i], i % 8);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int         order[$];
        logic [7:0] prev;
        apply_reset();
        req = 8'h40;
        cycle();
        req = 8'h00;
        cycle();
        req  = 8'h81;
        prev = 8'h00;
        for (int c = 0; c < 12; c++) begin
            in = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            n_checks++;
            if ({gnt, sel, out, out_valid} !== expected())
                $display("FAIL wrap cyc%0d: dut=%h model=%h", c, {gnt, sel, out, out_valid}, expected());
            else n_pass++;
            if (gnt !== 8'h00 && prev === 8'h00) order.push_back(idx_of(gnt));
            prev = gnt;
        end
        n_checks++;
        if (order.size() < 2 || order[0] != 7 || order[1] != 0)
            $display("FAIL wrap_order: got=%p want 7 then 0", order);
        else n_pass++;
    endtask

    task automatic test_early_release();
        logic [15:0] last;
        apply_reset();
        req = 8'h08;
        cycle();
        for (int b = 0; b < 2; b++) begin
            last        = 16'($urandom);
            in          = {$urandom, $urandom, $urandom, $urandom};
            in[63:48]   = last;
            cycle();
            n_checks++;
            if ({gnt, sel, out, out_valid} !== expected())
                $display("FAIL early beat%0d: dut=%h model=%h", b, {gnt, sel, out, out_valid}, expected());
            else n_pass++;
        end
        req = 8'h00;
        in  = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        n_checks++;
        if (out_valid !== 1'b0 || out !== last || gnt !== 8'h00)
            $display("FAIL early_release: v=%b out=%h gnt=%h want 0 %h 00", out_valid, out, gnt, last);
        else n_pass++;
        req = 8'hFF;
        cycle();
        n_checks++;
        if (gnt !== 8'h10 || {gnt, sel, out, out_valid} !== expected())
            $display("FAIL early_next_ptr: dut=%h model=%h", {gnt, sel, out, out_valid}, expected());
        else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        req = 8'($urandom);
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 8; k++) if ($urandom_range(0, 5) == 0) req[k] = ~req[k];
            in = {$urandom, $urandom, $urandom, $urandom};
`ifdef ARB_LOCK_EN
            lock = ($urandom_range(0, 3) == 0);
`endif
            cycle();
            n_checks++;
            if ({gnt, sel, out, out_valid} !== expected())
                $display("FAIL random cyc%0d: dut=%h model=%h", c, {gnt, sel, out, out_valid}, expected());
            else n_pass++;
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        int beats_seen;
        apply_reset();
        req  = 8'h20;
        lock = 1'b1;
        cycle();
        beats_seen = 0;
        for (int c = 0; c < 10; c++) begin
            in = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            if (out_valid === 1'b1 && gnt === 8'h20) beats_seen++;
            n_checks++;
            if ({gnt, sel, out, out_valid} !== expected())
                $display("FAIL lock cyc%0d: dut=%h model=%h", c, {gnt, sel, out, out_valid}, expected());
            else n_pass++;
        end
        n_checks++;
        if (beats_seen != 10) $display("FAIL lock_beats: got=%0d want=10", beats_seen);
        else n_pass++;
        lock = 1'b0;
        cycle();
        n_checks++;
        if (gnt !== 8'h00 || out_valid !== 1'b1)
            $display("FAIL lock_release: gnt=%h v=%b want 00 1", gnt, out_valid);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_early_release();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
